// File: rtl/grf_operand_stage.sv
// Operand-fetch stage: 32-entry register file, two read ports with write-back bypass,
// and a one-deep valid/ready register delivering {A, B, op} to the ALU.
module grf_operand_stage #(
  parameter int unsigned NREG = 32,
  parameter int unsigned DW   = 32,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [DW-1:0] in_imm,
  input  logic          in_use_imm,
  input  logic [2:0]    in_op,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_A,
  output logic [DW-1:0] out_B,
  output logic [2:0]    out_op
);

  logic [DW-1:0] grf_q [NREG];

  logic          valid_q, valid_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] rs_q, rs_d;
  logic [AW-1:0] rt_q, rt_d;
  logic          use_imm_q, use_imm_d;

  logic          wb_we;
  logic          accept;
  logic          consume;
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;

  assign wb_we    = wb_en && (wb_addr != '0);
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = valid_q && out_ready;

  // Read ports: register 0 is hard zero, a same-cycle write-back wins over the stored value.
  always_comb begin
    rd_a = '0;
    if (in_rs != '0) begin
      rd_a = (wb_we && (wb_addr == in_rs)) ? wb_data : grf_q[in_rs];
    end
  end

  always_comb begin
    rd_b = '0;
    if (in_use_imm) begin
      rd_b = in_imm;
    end else if (in_rt != '0) begin
      rd_b = (wb_we && (wb_addr == in_rt)) ? wb_data : grf_q[in_rt];
    end
  end

  // Next state of the held entry: load on accept, drop on consume, otherwise keep the
  // stalled operands coherent with write-backs that land while the ALU is not ready.
  always_comb begin
    valid_d   = valid_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    use_imm_d = use_imm_q;
    if (accept) begin
      valid_d   = 1'b1;
      a_d       = rd_a;
      b_d       = rd_b;
      op_d      = in_op;
      rs_d      = in_rs;
      rt_d      = in_rt;
      use_imm_d = in_use_imm;
    end else if (consume) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // wb_we already excludes register 0, so a held rs/rt of 0 never matches.
      if (wb_we && (wb_addr == rs_q)) begin
        a_d = wb_data;
      end
      if (wb_we && !use_imm_q && (wb_addr == rt_q)) begin
        b_d = wb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      use_imm_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      use_imm_q <= use_imm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        grf_q[i] <= '0;
      end
    end else if (wb_we) begin
      grf_q[wb_addr] <= wb_data;
    end
  end

  assign out_valid = valid_q;
  assign out_A     = a_q;
  assign out_B     = b_q;
  assign out_op    = op_q;

endmodule
